// File: rtl/bxu_pkg.sv
// Shared definitions for the byte-stream utility blocks.
//   CHAR_*      : control characters recognised by the line assembler
//   la_state_e  : line assembler state encoding
package bxu_pkg;

  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_BS  = 8'h08;
  localparam logic [7:0] CHAR_DEL = 8'h7F;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EMIT    = 2'd1,
    ST_EMIT_CR = 2'd2,
    ST_EMIT_LF = 2'd3
  } la_state_e;

endpackage

// File: rtl/line_store.sv
// Line store: synchronous single-port RAM, DEPTH x DATA_W, registered read.
// A read happens every cycle at addr_i; on a write cycle the old contents are
// returned. No reset on the array so it maps onto distributed RAM.
//   clk_i   : clock
//   we_i    : write enable
//   addr_i  : shared read/write address
//   wdata_i : write data
//   rdata_o : read data, valid the cycle after addr_i is presented
module line_store #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/line_assembler.sv
// Line assembler: collects received bytes into a line store and, on a line
// terminator (CR, or a lone LF), replays the stored line downstream followed
// by CR LF. An LF directly after a CR is swallowed so CRLF input yields one
// line. Both sides use a four-phase ready/done byte handshake.
// Optional build macro: LINE_ASSEMBLER_BACKSPACE_EN -- when defined, 0x08 and
// 0x7F delete the last stored byte instead of being stored.
//   clk       : clock
//   rst       : asynchronous reset, active-high
//   data_in   : upstream byte, valid while ready_in is high
//   ready_in  : upstream offers a byte
//   done_in   : one-cycle acknowledge of the upstream byte
//   data_out  : downstream byte, stable while ready_out is high
//   ready_out : byte offered downstream
//   done_out  : downstream acknowledge
//   line_len  : number of bytes currently stored
//   overflow  : sticky, a byte was dropped on a full store; cleared once the
//               line has been emitted
module line_assembler
  import bxu_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             data_in,
  input  logic                   ready_in,
  output logic                   done_in,
  output logic [7:0]             data_out,
  output logic                   ready_out,
  input  logic                   done_out,
  output logic [$clog2(DEPTH):0] line_len,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  la_state_e     state_q, state_d;
  logic [LW-1:0] line_len_q, line_len_d;
  logic [LW-1:0] emit_idx_q, emit_idx_d;
  logic          prev_cr_q, prev_cr_d;
  logic          ovf_q, ovf_d;
  logic          armed_q, armed_d;
  logic          done_in_q, done_in_d;
  logic          ready_out_q, ready_out_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          wait_low_q, wait_low_d;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_rdata;

  // The port is shared: writes use line_len, otherwise the address follows the
  // emit pointer. While collecting, the pointer sits at 0, so mem[0] is already
  // in the read register when the terminator arrives.
  assign ram_addr = ram_we ? line_len_q[AW-1:0] : emit_idx_q[AW-1:0];

  line_store #(
    .DEPTH  (DEPTH),
    .DATA_W (8)
  ) u_store (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (data_in),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    line_len_d  = line_len_q;
    emit_idx_d  = emit_idx_q;
    prev_cr_d   = prev_cr_q;
    ovf_d       = ovf_q;
    armed_d     = armed_q;
    done_in_d   = 1'b0;
    ready_out_d = ready_out_q;
    data_out_d  = data_out_q;
    wait_low_d  = wait_low_q;
    ram_we      = 1'b0;

    // Input side re-arms once ready_in has been seen low.
    if (!ready_in) begin
      armed_d = 1'b1;
    end
    // Output side may offer the next byte once done_out has been seen low.
    if (!done_out) begin
      wait_low_d = 1'b0;
    end

    case (state_q)
      ST_COLLECT: begin
        if (ready_in && armed_q) begin
          armed_d   = 1'b0;
          done_in_d = 1'b1;
          if (data_in == CHAR_CR) begin
            state_d   = (line_len_q == '0) ? ST_EMIT_CR : ST_EMIT;
            prev_cr_d = 1'b1;
          end else if (data_in == CHAR_LF) begin
            if (prev_cr_q) begin
              prev_cr_d = 1'b0;
            end else begin
              state_d = (line_len_q == '0) ? ST_EMIT_CR : ST_EMIT;
            end
`ifdef LINE_ASSEMBLER_BACKSPACE_EN
          end else if (data_in == CHAR_BS || data_in == CHAR_DEL) begin
            prev_cr_d = 1'b0;
            if (line_len_q != '0) begin
              line_len_d = line_len_q - 1'b1;
            end
`endif
          end else begin
            prev_cr_d = 1'b0;
            if (line_len_q < DEPTH_L) begin
              ram_we     = 1'b1;
              line_len_d = line_len_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end

      default: begin
        if (!ready_out_q && (!wait_low_q || !done_out)) begin
          ready_out_d = 1'b1;
          wait_low_d  = 1'b0;
          case (state_q)
            ST_EMIT: begin
              data_out_d = ram_rdata;
              // Advancing here lets the RAM fetch the next byte while this
              // one is in flight.
              emit_idx_d = emit_idx_q + 1'b1;
            end
            ST_EMIT_CR: data_out_d = CHAR_CR;
            default:    data_out_d = CHAR_LF;
          endcase
        end else if (ready_out_q && done_out) begin
          ready_out_d = 1'b0;
          wait_low_d  = 1'b1;
          case (state_q)
            ST_EMIT: begin
              if (emit_idx_q == line_len_q) begin
                state_d = ST_EMIT_CR;
              end
            end
            ST_EMIT_CR: state_d = ST_EMIT_LF;
            default: begin
              state_d    = ST_COLLECT;
              line_len_d = '0;
              emit_idx_d = '0;
              ovf_d      = 1'b0;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      line_len_q  <= '0;
      emit_idx_q  <= '0;
      prev_cr_q   <= 1'b0;
      ovf_q       <= 1'b0;
      armed_q     <= 1'b1;
      done_in_q   <= 1'b0;
      ready_out_q <= 1'b0;
      data_out_q  <= 8'h00;
      wait_low_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_len_q  <= line_len_d;
      emit_idx_q  <= emit_idx_d;
      prev_cr_q   <= prev_cr_d;
      ovf_q       <= ovf_d;
      armed_q     <= armed_d;
      done_in_q   <= done_in_d;
      ready_out_q <= ready_out_d;
      data_out_q  <= data_out_d;
      wait_low_q  <= wait_low_d;
    end
  end

  assign done_in   = done_in_q;
  assign ready_out = ready_out_q;
  assign data_out  = data_out_q;
  assign line_len  = line_len_q;
  assign overflow  = ovf_q;

endmodule
